// File: rtl/quad_velocity.sv
// quad_velocity: converts a free-running quadrature position count into a
// signed, saturated per-window velocity, with direction and stall flags.
// The first window after reset only primes the reference position.
module quad_velocity #(
  parameter int CNT_W         = 22,
  parameter int WIN_CYCLES    = 1000,
  parameter int VEL_W         = 16,
  parameter int STALL_WINDOWS = 4
) (
  input  logic                    clk,
  input  logic                    nrst,   // active-high despite the name
  input  logic [CNT_W-1:0]        count,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid,
  output logic                    dir,
  output logic                    sat,
  output logic                    stalled
);

  localparam int WIN_W = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
  localparam logic [7:0]       STALL_MAX = 8'(STALL_WINDOWS);

  // Velocity limits expressed at the delta width so the comparison is a
  // plain signed compare without any truncation.
  localparam logic signed [CNT_W-1:0] VEL_MAX =
    {{(CNT_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] VEL_MIN =
    {{(CNT_W-VEL_W+1){1'b1}}, {(VEL_W-1){1'b0}}};

  typedef enum logic {PRIME, RUN} state_t;

  state_t                  state;
  logic [WIN_W-1:0]        win_cnt;
  logic [CNT_W-1:0]        prev;
  logic [7:0]              zero_cnt;
  logic                    term;
  logic signed [CNT_W-1:0] delta_p0;
  logic [VEL_W:0]          clip_p0;   // {clipped flag, clipped velocity}
  logic [7:0]              zero_nxt;

  // Clip a signed delta into the velocity range; MSB of the result flags a clip.
  function automatic logic [VEL_W:0] saturate(input logic signed [CNT_W-1:0] d);
    if (d > VEL_MAX)
      return {1'b1, VEL_MAX[VEL_W-1:0]};
    else if (d < VEL_MIN)
      return {1'b1, VEL_MIN[VEL_W-1:0]};
    else
      return {1'b0, d[VEL_W-1:0]};
  endfunction

  // Terminal-edge detect, modulo delta (handles counter wrap) and clipping.
  always_comb begin
    term     = (win_cnt == WIN_LAST);
    delta_p0 = $signed(count - prev);
    clip_p0  = saturate(delta_p0);
    zero_nxt = (zero_cnt == STALL_MAX) ? zero_cnt : zero_cnt + 8'd1;
  end

  // Measurement window counter, 0..WIN_CYCLES-1.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst)
      win_cnt <= '0;
    else if (term)
      win_cnt <= '0;
    else
      win_cnt <= win_cnt + WIN_W'(1);
  end

  // PRIME/RUN state machine producing all registered outputs at terminal edges.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state     <= PRIME;
      prev      <= '0;
      vel       <= '0;
      vel_valid <= 1'b0;
      dir       <= 1'b0;
      sat       <= 1'b0;
      stalled   <= 1'b0;
      zero_cnt  <= '0;
    end else begin
      vel_valid <= 1'b0;
      if (term) begin
        prev <= count;
        case (state)
          PRIME: begin
            state <= RUN;
          end
          RUN: begin
            vel       <= $signed(clip_p0[VEL_W-1:0]);
            sat       <= clip_p0[VEL_W];
            vel_valid <= 1'b1;
            if (delta_p0 != '0) begin
              dir      <= ~delta_p0[CNT_W-1];
              zero_cnt <= '0;
              stalled  <= 1'b0;
            end else begin
              zero_cnt <= zero_nxt;
              stalled  <= (zero_nxt == STALL_MAX);
            end
          end
          default: state <= PRIME;
        endcase
      end
    end
  end

endmodule

// File: doc/quad_velocity.md
QUAD_VELOCITY -- requirements
Module: quad_velocity

Interface
REQ-001 Parameter CNT_W, default 22, width of the position count input from the quadrature decoder.
REQ-002 Parameter WIN_CYCLES, default 1000, measurement window length in clk cycles (legal range 2..2^20).
REQ-003 Parameter VEL_W, default 16, width of the signed velocity output (legal VEL_W <= CNT_W).
REQ-004 Parameter STALL_WINDOWS, default 4, number of consecutive zero-delta windows that flags a stall (legal 1..255).
REQ-005 clk  input  1  single system clock; all state updates on rising edge.
REQ-006 nrst  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-007 count  input  CNT_W  unsigned position count from the quadrature decoder, synchronous to clk, wraps modulo 2^CNT_W.
REQ-008 vel  output  VEL_W  signed two's-complement count delta over the last completed window, saturated.
REQ-009 vel_valid  output  1  one-cycle pulse marking a new vel value.
REQ-010 dir  output  1  direction of the last nonzero delta: 1 = increasing, 0 = decreasing.
REQ-011 sat  output  1  set when the current vel value was clipped; updated with each vel_valid.
REQ-012 stalled  output  1  high while the last STALL_WINDOWS or more windows all had zero delta.

Function
REQ-013 Window counter runs 0..WIN_CYCLES-1 and wraps to 0; the "terminal edge" is the rising edge at which it equals WIN_CYCLES-1.
REQ-014 State machine with two states: PRIME (after reset) and RUN; no other states.
REQ-015 PRIME: at the first terminal edge, count is captured into prev, no vel_valid is issued, and the state moves to RUN.
REQ-016 RUN: at each terminal edge, delta = (count - prev) mod 2^CNT_W, interpreted as a signed CNT_W value; prev <= count.
REQ-017 Wrap-around is handled by the modulo rule: prev=2^CNT_W-2, count=1 gives delta=+3; prev=1, count=2^CNT_W-2 gives delta=-3.
REQ-018 Saturation: delta > 2^(VEL_W-1)-1 gives vel = 2^(VEL_W-1)-1; delta < -2^(VEL_W-1) gives vel = -2^(VEL_W-1); sat=1 in either case, otherwise sat=0.
REQ-019 vel, sat, dir and stalled are registered at the terminal edge; vel_valid=1 for exactly the one cycle following that edge (latency 1 edge from sampling).
REQ-020 vel and sat hold their values between vel_valid pulses.
REQ-021 dir <= 1 if delta>0, 0 if delta<0, unchanged if delta==0.
REQ-022 Zero-window counter increments (saturating at STALL_WINDOWS) on each RUN window with delta==0 and clears on any nonzero delta.
REQ-023 stalled = 1 when that counter equals STALL_WINDOWS, and falls at the same terminal edge that produces the first nonzero delta.
REQ-024 count changing on the terminal edge itself is sampled with the value present before that edge; no separate synchronizer (input already synchronous).
REQ-025 vel_valid is never asserted in two consecutive cycles (guaranteed by WIN_CYCLES>=2).

Reset
REQ-026 While nrst=1: vel=0, vel_valid=0, dir=0, sat=0, stalled=0, prev=0, window counter=0, zero-window counter=0, state=PRIME.
REQ-027 Reset asserted mid-window discards the partial window; after release, the first terminal edge occurs WIN_CYCLES edges later and only primes (no vel_valid).

Verification (bench with WIN_CYCLES=8, VEL_W=8, STALL_WINDOWS=2, CNT_W=22)
REQ-028 Reset then count held 100 -> no vel_valid at first terminal edge; 2nd window vel=0, vel_valid pulse, stalled=0; 3rd window stalled=1.
REQ-029 count +5 per window (100,105,110) -> vel=+5, dir=1, sat=0 on each pulse; pulses exactly 8 cycles apart; stalled clears on first nonzero window.
REQ-030 count 0x3FFFFE then 0x000001 in the next window -> vel=+3, dir=1; reverse sequence -> vel=-3, dir=0.
REQ-031 count jump +300 in one window -> vel=127, sat=1; then -300 -> vel=-128, sat=1; next +1 window -> vel=1, sat=0.
REQ-032 nrst pulsed at window cycle 4 while RUN -> all outputs 0 asynchronously; no vel_valid until the second terminal edge after release.
REQ-033 Zero-delta window following +5 window -> vel=0, dir stays 1.
